rv_bits_remove_demux: RTL and testbench

- Receive side of the tag-insert path: accepts a word carrying an S-bit select field at bit position POS, strips the field back out, and routes the remaining N-bit payload to output lane sel.
- Sits on response return paths (e.g. memory/cache responses tagged with a requester index) ahead of per-requester consumers.
- Fully registered valid/ready pipeline with a one-entry skid buffer, so it sustains 1 word/cycle.
- Drops words whose tag ≥ NUM_OUT, flags them and counts them.

---
 rtl/rv_bits_remove_demux_pkg.sv | 20 ++
 rtl/rv_bits_remove.sv | 23 ++
 rtl/rv_bits_remove_demux.sv | 128 ++++++++++++
 tb/tb_rv_bits_remove_demux.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_bits_remove_demux_pkg.sv
// Shared width helpers and parameter legality checks for the tag insert/remove path.
package rv_bits_remove_demux_pkg;

    function automatic int tagged_width(input int n, input int s);
        return n + s;
    endfunction

    function automatic int lane_width(input int num_out);
        return (num_out > 1) ? $clog2(num_out) : 1;
    endfunction

    function automatic bit pos_legal(input int pos, input int n);
        return (pos >= 0) && (pos <= n);
    endfunction

    function automatic bit lanes_legal(input int num_out, input int s);
        return (num_out >= 1) && (num_out <= (1 << s));
    endfunction

endpackage

// File: rtl/rv_bits_remove.sv
// Strips an S-bit select field at bit POS out of an (N+S)-bit word; inverse of the insert stage.
module rv_bits_remove #(
    parameter int N   = 32,
    parameter int S   = 2,
    parameter int POS = 0
) (
    input  logic [N+S-1:0] data_in,
    output logic [N-1:0]   data_out,
    output logic [S-1:0]   sel_out
);

    if (POS == 0) begin : g_field_lsb
        assign sel_out  = data_in[S-1:0];
        assign data_out = data_in[N+S-1:S];
    end else if (POS == N) begin : g_field_msb
        assign sel_out  = data_in[N+S-1:N];
        assign data_out = data_in[N-1:0];
    end else begin : g_field_mid
        assign sel_out  = data_in[POS+S-1:POS];
        assign data_out = {data_in[N+S-1:POS+S], data_in[POS-1:0]};
    end

endmodule

// File: rtl/rv_bits_remove_demux.sv
// Removes the select field from each tagged word and steers the payload to one of NUM_OUT
// lanes through a main register plus one-entry skid; out-of-range tags are dropped and counted.
module rv_bits_remove_demux
    import rv_bits_remove_demux_pkg::*;
#(
    parameter int N       = 32,
    parameter int S       = 2,
    parameter int POS     = 0,
    parameter int NUM_OUT = 4,
    parameter int CNT_W   = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic [tagged_width(N, S)-1:0]   in_data,
    output logic                            in_ready,
    output logic [NUM_OUT-1:0]              out_valid,
    output logic [N-1:0]                    out_data,
    input  logic [NUM_OUT-1:0]              out_ready,
    output logic                            drop_pulse,
    output logic [CNT_W-1:0]                drop_count
);

    localparam int          LW        = lane_width(NUM_OUT);
    localparam logic [31:0] NUM_OUT_U = 32'(NUM_OUT);

    if (!pos_legal(POS, N)) begin : g_bad_pos
        $error("rv_bits_remove_demux: POS must lie in 0..N");
    end
    if (!lanes_legal(NUM_OUT, S)) begin : g_bad_lanes
        $error("rv_bits_remove_demux: NUM_OUT must lie in 1..2**S");
    end

    logic [N-1:0] pay_w;
    logic [S-1:0] sel_w;

    rv_bits_remove #(.N(N), .S(S), .POS(POS)) u_remove (
        .data_in  (in_data),
        .data_out (pay_w),
        .sel_out  (sel_w)
    );

    logic             m_valid_q, m_valid_d;
    logic [LW-1:0]    m_sel_q, m_sel_d;
    logic [N-1:0]     m_data_q, m_data_d;
    logic             s_valid_q, s_valid_d;
    logic [LW-1:0]    s_sel_q, s_sel_d;
    logic [N-1:0]     s_data_q, s_data_d;
    logic             drop_pulse_q, drop_pulse_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;

    logic accept, in_range, take, drop, pop;

    always_comb begin
        in_ready  = reset & ~s_valid_q;
        accept    = in_valid & in_ready;
        in_range  = 32'(sel_w) < NUM_OUT_U;
        take      = accept & in_range;
        drop      = accept & ~in_range;
        out_valid = m_valid_q ? (NUM_OUT'(1) << m_sel_q) : '0;
        out_data  = m_data_q;
        pop       = |(out_valid & out_ready);

        m_valid_d = m_valid_q;
        m_sel_d   = m_sel_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_sel_d   = s_sel_q;
        s_data_d  = s_data_q;

        // Main is always the oldest word; skid only ever holds the next one in order.
        if (pop) begin
            if (s_valid_q) begin
                m_sel_d  = s_sel_q;
                m_data_d = s_data_q;
                if (take) begin
                    s_sel_d  = sel_w[LW-1:0];
                    s_data_d = pay_w;
                end else begin
                    s_valid_d = 1'b0;
                end
            end else if (take) begin
                m_sel_d  = sel_w[LW-1:0];
                m_data_d = pay_w;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (take) begin
            if (!m_valid_q) begin
                m_valid_d = 1'b1;
                m_sel_d   = sel_w[LW-1:0];
                m_data_d  = pay_w;
            end else begin
                s_valid_d = 1'b1;
                s_sel_d   = sel_w[LW-1:0];
                s_data_d  = pay_w;
            end
        end

        drop_pulse_d = drop;
        drop_count_d = (drop && !(&drop_count_q)) ? drop_count_q + CNT_W'(1) : drop_count_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            m_valid_q    <= 1'b0;
            s_valid_q    <= 1'b0;
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            m_valid_q    <= m_valid_d;
            s_valid_q    <= s_valid_d;
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_ff @(posedge clk) begin
        m_sel_q  <= m_sel_d;
        m_data_q <= m_data_d;
        s_sel_q  <= s_sel_d;
        s_data_q <= s_data_d;
    end

    assign drop_pulse = drop_pulse_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_rv_bits_remove_demux.sv
// Three instances (POS=0/16/32) driven one at a time, checked every cycle against a FIFO model.
module tb_rv_bits_remove_demux;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [33:0] in_data;
    logic [3:0]  out_ready;
    int          act;

    logic       iv0, iv1, iv2;
    logic       ir0, ir1, ir2;
    logic [3:0] ov0, ov1;
    logic [2:0] ov2;
    logic [31:0] od0, od1, od2;
    logic       dp0, dp1, dp2;
    logic [7:0] dc0, dc1, dc2;

    always #5 clk = ~clk;

    assign iv0 = in_valid && (act == 0);
    assign iv1 = in_valid && (act == 1);
    assign iv2 = in_valid && (act == 2);

    rv_bits_remove_demux #(.N(32), .S(2), .POS(0), .NUM_OUT(4), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .in_valid(iv0), .in_data(in_data), .in_ready(ir0),
        .out_valid(ov0), .out_data(od0), .out_ready(out_ready),
        .drop_pulse(dp0), .drop_count(dc0));

    rv_bits_remove_demux #(.N(32), .S(2), .POS(16), .NUM_OUT(4), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_data(in_data), .in_ready(ir1),
        .out_valid(ov1), .out_data(od1), .out_ready(out_ready),
        .drop_pulse(dp1), .drop_count(dc1));

    rv_bits_remove_demux #(.N(32), .S(2), .POS(32), .NUM_OUT(3), .CNT_W(8)) dut2 (
        .clk(clk), .reset(reset), .in_valid(iv2), .in_data(in_data), .in_ready(ir2),
        .out_valid(ov2), .out_data(od2), .out_ready(out_ready[2:0]),
        .drop_pulse(dp2), .drop_count(dc2));

    logic        o_ir, o_dp;
    logic [3:0]  o_ov;
    logic [31:0] o_od;
    logic [7:0]  o_dc;

    always_comb begin
        o_ir = ir0; o_ov = ov0; o_od = od0; o_dp = dp0; o_dc = dc0;
        if (act == 1) begin
            o_ir = ir1; o_ov = ov1; o_od = od1; o_dp = dp1; o_dc = dc1;
        end else if (act == 2) begin
            o_ir = ir2; o_ov = {1'b0, ov2}; o_od = od2; o_dp = dp2; o_dc = dc2;
        end
    end

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    bit          exp_pulse;
    int          exp_cnt[3];
    bit          acc_last;
    logic [1:0]  cur_sel;
    logic [31:0] cur_pay;
    int          checks = 0;
    int          failures = 0;

    function automatic int pos_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 16 : 32;
    endfunction

    function automatic int nout_of(input int k);
        return (k == 2) ? 3 : 4;
    endfunction

    // Builds the tagged word arithmetically: payload bits above pos shift up by the field width.
    function automatic logic [33:0] insert_tag(input logic [31:0] pay, input logic [1:0] sel, input int pos);
        logic [63:0] p, lo, hi, w;
        p  = 64'(pay);
        lo = p & ((64'd1 << pos) - 64'd1);
        hi = p >> pos;
        w  = (hi << (pos + 2)) | (64'(sel) << pos) | lo;
        return w[33:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input logic [1:0] sel, input logic [31:0] pay);
        cur_sel  = sel;
        cur_pay  = pay;
        in_data  = insert_tag(pay, sel, pos_of(act));
        in_valid = 1'b1;
    endtask

    task automatic check_outputs();
        logic [3:0] exp_ov;
        exp_ov = (q.size() != 0) ? (4'd1 << q[0].sel) : 4'd0;
        chk("out_valid", 64'(o_ov), 64'(exp_ov));
        if (q.size() != 0) chk("out_data", 64'(o_od), 64'(q[0].data));
        chk("in_ready", 64'(o_ir), 64'(reset && (q.size() < 2)));
        chk("drop_pulse", 64'(o_dp), 64'(exp_pulse));
        chk("drop_count", 64'(o_dc), 64'(exp_cnt[act]));
    endtask

    task automatic model_update();
        bit rdy, pop;
        acc_last = 1'b0;
        if (!reset) begin
            q.delete();
            exp_pulse = 1'b0;
            foreach (exp_cnt[k]) exp_cnt[k] = 0;
        end else begin
            rdy = q.size() < 2;
            pop = (q.size() != 0) && out_ready[q[0].sel];
            if (pop) void'(q.pop_front());
            exp_pulse = 1'b0;
            if (in_valid && rdy) begin
                acc_last = 1'b1;
                if (int'(cur_sel) < nout_of(act)) begin
                    q.push_back('{sel: cur_sel, data: cur_pay});
                end else begin
                    exp_pulse = 1'b1;
                    if (exp_cnt[act] < 255) exp_cnt[act]++;
                end
            end
        end
    endtask

    task automatic tick();
        #1;
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 4'hF;
        repeat (3) tick();
    endtask

    initial begin
        int n_out;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 4'h0;
        act       = 0;
        cur_sel   = '0;
        cur_pay   = '0;
        exp_pulse = 1'b0;
        foreach (exp_cnt[k]) exp_cnt[k] = 0;
        repeat (2) @(posedge clk);
        #1;
        tick();
        reset = 1'b1;
        tick();

        // Single word, POS=0, lane 2
        out_ready = 4'hF;
        set_word(2'd2, 32'hDEADBEEF);
        in_data = {32'hDEADBEEF, 2'b10};
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", 64'(o_ov), 64'(4'b0100));
        chk("t1_out_data", 64'(o_od), 64'h0DEADBEEF);
        tick();
        chk("t1_out_valid_clear", 64'(o_ov), 64'(4'b0000));
        drain();

        // POS=16, field in the middle
        act = 1;
        set_word(2'd3, 32'hABCD1234);
        in_data = {16'hABCD, 2'b11, 16'h1234};
        tick();
        in_valid = 1'b0;
        chk("pos16_out_valid", 64'(o_ov), 64'(4'b1000));
        chk("pos16_out_data", 64'(o_od), 64'hABCD1234);
        drain();

        // Single out-of-range word, then saturation of the drop counter
        act = 2;
        set_word(2'd3, $urandom);
        tick();
        in_valid = 1'b0;
        chk("drop_no_valid", 64'(o_ov), 64'd0);
        chk("drop_pulse_hi", 64'(o_dp), 64'd1);
        chk("drop_count_1", 64'(o_dc), 64'd1);
        tick();
        chk("drop_pulse_lo", 64'(o_dp), 64'd0);
        set_word(2'd3, $urandom);
        repeat (300) tick();
        in_valid = 1'b0;
        tick();
        chk("drop_count_sat", 64'(o_dc), 64'd255);
        drain();

        // Random traffic with random backpressure on each instance
        for (int k = 0; k < 3; k++) begin
            act = k;
            in_valid = 1'b0;
            acc_last = 1'b0;
            for (int i = 0; i < 60; i++) begin
                if (!in_valid || acc_last) begin
                    if ($urandom_range(0, 3) != 0) set_word(2'($urandom_range(0, 3)), $urandom);
                    else in_valid = 1'b0;
                end
                out_ready = 4'($urandom);
                tick();
            end
            drain();
        end

        // Directed backpressure: A(sel0), B(sel1), C(sel2)
        act = 0;
        out_ready = 4'h0;
        set_word(2'd0, 32'hAAAA0000);
        tick();
        set_word(2'd1, 32'hBBBB1111);
        tick();
        set_word(2'd2, 32'hCCCC2222);
        chk("bp_in_ready_low", 64'(o_ir), 64'd0);
        tick();
        tick();
        chk("bp_head_A", 64'(o_od), 64'hAAAA0000);
        chk("bp_lane0", 64'(o_ov), 64'(4'b0001));
        out_ready = 4'b0001;
        tick();
        chk("bp_head_B", 64'(o_od), 64'hBBBB1111);
        chk("bp_lane1", 64'(o_ov), 64'(4'b0010));
        chk("bp_in_ready_high", 64'(o_ir), 64'd1);
        tick();
        in_valid = 1'b0;
        out_ready = 4'hF;
        tick();
        chk("bp_head_C", 64'(o_od), 64'hCCCC2222);
        chk("bp_lane2", 64'(o_ov), 64'(4'b0100));
        tick();
        chk("bp_empty", 64'(o_ov), 64'd0);
        drain();

        // Streaming 100 words back to back
        out_ready = 4'hF;
        n_out = 0;
        for (int i = 0; i < 100; i++) begin
            set_word(2'($urandom_range(0, 3)), $urandom);
            tick();
            if (o_ov != 4'd0) n_out++;
        end
        in_valid = 1'b0;
        tick();
        if (o_ov != 4'd0) n_out++;
        chk("stream_count", 64'(n_out), 64'd100);

        // Reset with main and skid full
        out_ready = 4'h0;
        set_word(2'd0, 32'h11111111);
        tick();
        set_word(2'd1, 32'h22222222);
        tick();
        set_word(2'd2, 32'h33333333);
        reset = 1'b0;
        tick();
        chk("rst_in_ready", 64'(o_ir), 64'd0);
        chk("rst_out_valid", 64'(o_ov), 64'd0);
        tick();
        reset = 1'b1;
        act = 2;
        #1;
        chk("rst_drop_count", 64'(o_dc), 64'd0);
        act = 0;
        tick();
        chk("rst_first_word", 64'(o_ov), 64'(4'b0100));
        chk("rst_first_data", 64'(o_od), 64'h33333333);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
